// File: rtl/cpu_core_pkg.sv
// Shared definitions for the parametrised load/operate core: op codes,
// instruction field positions, FSM states and the ALU op type.
package cpu_core_pkg;

  typedef logic [5:0] alu_op_t;

  localparam alu_op_t OP_NOP = 6'h00;
  localparam alu_op_t OP_AND = 6'h01;
  localparam alu_op_t OP_OR  = 6'h02;
  localparam alu_op_t OP_NOR = 6'h03;
  localparam alu_op_t OP_XOR = 6'h04;
  localparam alu_op_t OP_ADD = 6'h05;
  localparam alu_op_t OP_SUB = 6'h06;
  localparam alu_op_t OP_SLT = 6'h07;
  localparam alu_op_t OP_SLL = 6'h08;
  localparam alu_op_t OP_SRL = 6'h09;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SH_MSB = 10;
  localparam int SH_LSB = 6;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Only the ALU ops produce a register write; NOP and unknown codes do not.
  function automatic logic op_writes(input alu_op_t op);
    return (op >= OP_AND) && (op <= OP_SRL);
  endfunction

endpackage

// File: rtl/cpu_alu_param.sv
// Combinational ALU for cpu_core_param: logic ops, modular add/sub with
// signed-overflow detect, signed set-less-than and logical shifts of b.
module cpu_alu_param
  import cpu_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] result,
  output logic            ovf
);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOR: result = ~(a | b);
      OP_XOR: result = a ^ b;
      OP_ADD: begin
        result = a + b;
        ovf    = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        result = a - b;
        ovf    = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      OP_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: result = (int'(shamt) >= XLEN) ? '0 : (b << shamt);
      OP_SRL: result = (int'(shamt) >= XLEN) ? '0 : (b >> shamt);
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_core_param.sv
// Parametrised load/operate core with a 2-stage EX/WB pipeline and forwarding.
// Optional CPU_ZERO_REG_EN makes register 0 a hardwired zero.
module cpu_core_param
  import cpu_core_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lo,
  input  logic            wr,
  input  logic [AW-1:0]   rsm,
  input  logic [XLEN-1:0] man_in,
  input  logic            ins_valid,
  input  logic [31:0]     ins,
  output logic            load_ready,
  output logic            ov,
  input  logic [AW-1:0]   rb_sel,
  output logic [XLEN-1:0] rb_data
);

  logic [XLEN-1:0] regs [NREG];
  state_t          state;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_res;

  alu_op_t         op;
  logic [4:0]      rs, rt, rd, shamt;
  logic [XLEN-1:0] a_val, b_val, alu_res;
  logic            alu_ovf;
  logic            accept;
  logic            unused_ins;

  assign op         = ins[OP_MSB:OP_LSB];
  assign rs         = ins[RS_MSB:RS_LSB];
  assign rt         = ins[RT_MSB:RT_LSB];
  assign rd         = ins[RD_MSB:RD_LSB];
  assign shamt      = ins[SH_MSB:SH_LSB];
  assign unused_ins = ^ins[5:0];

  function automatic logic writable(input logic [4:0] idx);
    logic ok;
    ok = int'(idx) < NREG;
`ifdef CPU_ZERO_REG_EN
    if (idx == 5'd0) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Non-writable indices (out of range, or hardwired zero) also read as 0.
  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
    return writable(idx) ? regs[idx[AW-1:0]] : '0;
  endfunction

  // ex_valid is only ever set for a writable rd, so forwarding cannot leak
  // a value for a dropped write.
  always_comb begin
    a_val   = read_reg(rs);
    b_val   = read_reg(rt);
    rb_data = read_reg(5'(rb_sel));
    if (ex_valid && (ex_rd == rs)) a_val = ex_res;
    if (ex_valid && (ex_rd == rt)) b_val = ex_res;
  end

  cpu_alu_param #(.XLEN(XLEN)) u_alu (
    .op    (op),
    .a     (a_val),
    .b     (b_val),
    .shamt (shamt),
    .result(alu_res),
    .ovf   (alu_ovf)
  );

  // An instruction on the RUN->LOAD edge would be stranded, so only RUN
  // edges that stay in RUN or head into DRAIN accept one.
  assign accept = ins_valid && (lo || ex_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs       <= '{default: '0};
      state      <= ST_LOAD;
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_res     <= '0;
      ov         <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          if (wr && writable(5'(rsm))) regs[rsm] <= man_in;
          ex_valid <= 1'b0;
          if (lo) begin
            state      <= ST_RUN;
            ov         <= 1'b0;
            load_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ex_valid) regs[ex_rd[AW-1:0]] <= ex_res;
          ex_valid <= accept && op_writes(op) && writable(rd);
          ex_rd    <= rd;
          ex_res   <= alu_res;
          if (accept && alu_ovf) ov <= 1'b1;
          if (!lo) begin
            state      <= ex_valid ? ST_DRAIN : ST_LOAD;
            load_ready <= !ex_valid;
          end
        end
        ST_DRAIN: begin
          if (ex_valid) regs[ex_rd[AW-1:0]] <= ex_res;
          ex_valid   <= 1'b0;
          state      <= ST_LOAD;
          load_ready <= 1'b1;
        end
        default: begin
          ex_valid   <= 1'b0;
          state      <= ST_LOAD;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
Parametrised successor of the 8-register, 32-bit load/operate CPU core. It keeps the manual-load mode (rsm/man_in/wr) and the R-type operate mode, and generalises both register width and register count. It adds a 2-stage execute/writeback pipeline with forwarding, more ALU operations, a sticky signed-overflow flag, and a drain state for mode switching. Test benches and the top-level sit above it; the register file is observed through a readback port instead of flat per-register outputs.

Parameters:
XLEN, 32, datapath/register width (>=8)
NREG, 8, number of registers (2..32)
AW, $clog2(NREG), register select width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
lo  in  1  mode: 0 = load, 1 = operate
wr  in  1  load write enable (load mode only)
rsm  in  AW  load target register
man_in  in  XLEN  load data
ins_valid  in  1  instruction present (operate mode)
ins  in  32  instruction: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] ignored
load_ready  out  1  1 when a load is accepted this cycle
ov  out  1  sticky signed overflow
rb_sel  in  AW  readback select
rb_data  out  XLEN  combinational reg[rb_sel]

Behaviour:
- Reset (async): all registers 0, EX stage invalid, state LOAD, ov=0, load_ready=1.
- States: LOAD, RUN, DRAIN.
  - LOAD->RUN when lo=1. On this edge ov clears.
  - RUN->DRAIN when lo=0 and EX valid.
  - RUN->LOAD when lo=0 and EX invalid.
  - DRAIN->LOAD unconditionally after one cycle.
- LOAD: on each edge with wr=1, reg[rsm]<=man_in. load_ready=1 only in LOAD. wr is ignored in RUN/DRAIN and is not queued.
- RUN, stage 1 (edge k, ins_valid=1):
  - Operands are read combinationally.
  - Forwarding: if rs or rt equals the EX-stage rd and EX is valid, the EX result is used in place of the register value.
  - The ALU result is registered into EX (rd, result, valid).
- Stage 2 (edge k+1): EX result is written to reg[rd]. rb_data shows the new value after edge k+1. Back-to-back dependent instructions need no stall.
- ins_valid=0: a bubble enters EX, and a pending writeback still completes.
- Ops:
  - 000000 NOP
  - 000001 AND, 000010 OR, 000011 NOR, 000100 XOR
  - 000101 ADD, 000110 SUB (modulo 2^XLEN)
  - 000111 SLT: signed; result 1 or 0, zero-extended
  - 001000 SLL by shamt, 001001 SRL by shamt (shamt>=XLEN gives 0)
  - any other op: NOP
- ov is set on signed overflow of ADD/SUB when the op enters EX. It stays set until reset or the next LOAD->RUN.
- Register index >= NREG: reads return 0; writes are dropped (both load and writeback).
- DRAIN completes the pending writeback; new ins is ignored.
- Reset mid-pipeline discards the EX contents.
- NOP and unknown ops never write.

Optional Feature:
Macro CPU_ZERO_REG_EN.
- Defined: reg0 reads as 0 and ignores all writes (load and writeback). Forwarding never supplies a nonzero value for index 0.
- Undefined: reg0 is an ordinary register.

Decomposition:
- Package cpu_core_pkg: op-code localparams, instruction field bit positions, state enum (LOAD/RUN/DRAIN), alu_op typedef.
- One sub-module, cpu_alu_param: combinational, parametrised by XLEN; inputs op, a, b, shamt; outputs result and ovf.
- Register file, forwarding, EX stage and FSM stay in cpu_core_param.

Test Plan:
- XLEN=32, NREG=8. Load reg0=51, reg1=32, reg2=0. Then in RUN, back to back: NOR r3=r2,r2; AND r4=r0,r3; AND r5=r2,r1; OR r6=r4,r5. Expect r3=0xFFFFFFFF, r4=51, r5=0, r6=51; r6 is visible 1 edge after the last ins (forwarding exercised).
- Drop lo, load reg2=0xFFFFFFFF, rerun the same 4 instructions. Expect r3=0, r4=0, r5=32, r6=32. load_ready is 0 during the DRAIN cycle and the wr in that cycle is ignored.
- ADD r1=0x7FFFFFFF + r2=1 -> r3=0x80000000, ov=1. A following ADD without overflow leaves ov=1. LOAD->RUN clears ov.
- SUB 5-7 -> 0xFFFFFFFE. SLT(-2,3)=1. SLL 1 by shamt 31 = 0x80000000. SRL 0x80000000 by 31 = 1. Unknown op 0x3F leaves all registers unchanged.
- Assert reset while EX holds a write to r4. r4 stays 0, ov=0, state LOAD, load_ready=1.
- With CPU_ZERO_REG_EN: load reg0=51, then ADD r1=r0,r0. Expect rb_data(r0)=0 and r1=0. Without the macro: r0=51, r1=102.
